// File: rtl/spi_master_if.sv
// Handshake and serial bus bundle for spi_master: the local controller side
// (start/done/data) and the SPI wires to the slave.
`timescale 1ns/1ps
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] masterDataToSend;
  logic [DATA_WIDTH-1:0] masterDataReceived;
  logic                  busy;
  logic                  done;
  logic                  SCLK;
  logic                  CS;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  start, masterDataToSend, MISO,
    output masterDataReceived, busy, done, SCLK, CS, MOSI
  );

  modport slave (
    output start, masterDataToSend, MISO,
    input  masterDataReceived, busy, done, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Mode 0 SPI master: one full-duplex DATA_WIDTH-bit frame per accepted start.
// Define SPI_MASTER_MSB_FIRST_EN for MSB-first bit order (LSB-first otherwise).
`timescale 1ns/1ps
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic          clk,
  input  logic          reset,
  spi_master_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spiState;

  spiState               state, stateNext;
  logic [DIV_W-1:0]      divCnt, divNext;
  logic [BIT_W-1:0]      bitIdx, bitNext;
  logic                  sclk, sclkNext;
  logic                  cs, csNext;
  logic                  busy, busyNext;
  logic                  done, doneNext;
  logic [DATA_WIDTH-1:0] txShift, txNext;
  logic [DATA_WIDTH-1:0] rxShift, rxNext;
  logic [DATA_WIDTH-1:0] rxOut, rxOutNext;
  logic                  divTick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      divCnt  <= '0;
      bitIdx  <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      txShift <= '0;
      rxShift <= '0;
      rxOut   <= '0;
    end else begin
      state   <= stateNext;
      divCnt  <= divNext;
      bitIdx  <= bitNext;
      sclk    <= sclkNext;
      cs      <= csNext;
      busy    <= busyNext;
      done    <= doneNext;
      txShift <= txNext;
      rxShift <= rxNext;
      rxOut   <= rxOutNext;
    end
  end

  assign divTick = (divCnt == DIV_LAST);

  // A start landing in the done cycle is dropped so frames are always separated by idle time.
  always_comb begin
    stateNext = state;
    divNext   = divCnt;
    bitNext   = bitIdx;
    sclkNext  = sclk;
    csNext    = cs;
    busyNext  = busy;
    doneNext  = 1'b0;
    txNext    = txShift;
    rxNext    = rxShift;
    rxOutNext = rxOut;
    case (state)
      IDLE: begin
        divNext = '0;
        bitNext = '0;
        if (bus.start && !done) begin
          txNext    = bus.masterDataToSend;
          csNext    = 1'b0;
          busyNext  = 1'b1;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        if (divTick) begin
          divNext   = '0;
          stateNext = SHIFT;
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      SHIFT: begin
        if (divTick) begin
          divNext  = '0;
          sclkNext = ~sclk;
          if (!sclk) begin
`ifdef SPI_MASTER_MSB_FIRST_EN
            rxNext = {rxShift[DATA_WIDTH-2:0], bus.MISO};
`else
            rxNext = {bus.MISO, rxShift[DATA_WIDTH-1:1]};
`endif
          end else if (bitIdx == BIT_LAST) begin
            bitNext   = '0;
            stateNext = HOLD;
          end else begin
            bitNext = bitIdx + 1'b1;
`ifdef SPI_MASTER_MSB_FIRST_EN
            txNext = {txShift[DATA_WIDTH-2:0], 1'b0};
`else
            txNext = {1'b0, txShift[DATA_WIDTH-1:1]};
`endif
          end
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      HOLD: begin
        if (divTick) begin
          divNext   = '0;
          csNext    = 1'b1;
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          rxOutNext = rxShift;
          stateNext = IDLE;
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // MOSI comes straight from the shift register end so it is a clean flop output.
`ifdef SPI_MASTER_MSB_FIRST_EN
  assign bus.MOSI = txShift[DATA_WIDTH-1];
`else
  assign bus.MOSI = txShift[0];
`endif
  assign bus.SCLK               = sclk;
  assign bus.CS                 = cs;
  assign bus.busy               = busy;
  assign bus.done               = done;
  assign bus.masterDataReceived = rxOut;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=2 instance against a Mode 0 slave model
// and a CLK_DIV=1 instance in MOSI->MISO loopback.
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spi_master_if #(.DATA_WIDTH(8)) bus0 ();
  spi_master_if #(.DATA_WIDTH(8)) bus1 ();

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  assign bus1.MISO = bus1.MOSI;

  // Slave model: first bit ready when CS falls, next bit after each SCLK fall.
  logic [7:0] slaveData = 8'h00;
  int slaveIdx = 0;

  always @(negedge bus0.SCLK or posedge bus0.CS) begin
    if (bus0.CS) slaveIdx = 0;
    else         slaveIdx = slaveIdx + 1;
  end

  always_comb begin
    bus0.MISO = 1'b0;
    if (slaveIdx < 8) begin
`ifdef SPI_MASTER_MSB_FIRST_EN
      bus0.MISO = slaveData[3'(7 - slaveIdx)];
`else
      bus0.MISO = slaveData[3'(slaveIdx)];
`endif
    end
  end

  // Free-running monitors; tests take baselines and compare differences.
  int riseCount0 = 0;
  int csLow0 = 0;
  int doneCount0 = 0;
  logic [7:0] mosiSeq0 = 8'h00;

  always @(posedge bus0.SCLK) begin
    mosiSeq0 = {bus0.MOSI, mosiSeq0[7:1]};
    riseCount0 = riseCount0 + 1;
  end

  always @(negedge clk) begin
    if (bus0.CS === 1'b0) csLow0 = csLow0 + 1;
    if (bus0.done === 1'b1) doneCount0 = doneCount0 + 1;
  end

  int runLow1 = 0;
  int runHigh1 = 0;
  int nLow1 = 0;
  int nDone1 = 0;
  int gap1 = 0;
  int lowLens1 [4];
  logic [7:0] rxLog1 [4];

  always @(negedge clk) begin
    if (bus1.CS === 1'b0) begin
      if (nLow1 > 0 && runHigh1 > 0) gap1 = runHigh1;
      runHigh1 = 0;
      runLow1 = runLow1 + 1;
    end else begin
      if (runLow1 > 0) begin
        if (nLow1 < 4) lowLens1[nLow1] = runLow1;
        nLow1 = nLow1 + 1;
      end
      runLow1 = 0;
      runHigh1 = runHigh1 + 1;
    end
    if (bus1.done === 1'b1) begin
      if (nDone1 < 4) rxLog1[nDone1] = bus1.masterDataReceived;
      nDone1 = nDone1 + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared = compared + 1;
    if (observed !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    bus0.masterDataToSend = data;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  task automatic waitDone0(input int limit);
    int n = 0;
    while (bus0.done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n = n + 1;
    end
    if (bus0.done !== 1'b1) checkOutput("done0Timeout", 32'd0, 32'd1);
  endtask

  int bRise, bCs, bDone;

  initial begin
    bus0.start = 1'b0;
    bus0.masterDataToSend = 8'h00;
    bus1.start = 1'b0;
    bus1.masterDataToSend = 8'h00;

    // Reset values
    #1 reset = 1'b0;
    #1;
    checkOutput("rstCS", 32'(bus0.CS), 32'd1);
    checkOutput("rstSCLK", 32'(bus0.SCLK), 32'd0);
    checkOutput("rstBusyDone", {30'd0, bus0.busy, bus0.done}, 32'd0);
    checkOutput("rstRxMosi", {23'd0, bus0.MOSI, bus0.masterDataReceived}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic frame
    slaveData = 8'h09;
    bRise = riseCount0; bCs = csLow0; bDone = doneCount0;
    applyStimulus(8'b01010011);
    checkOutput("t1Busy", 32'(bus0.busy), 32'd1);
    waitDone0(100);
    checkOutput("t1Rx", 32'(bus0.masterDataReceived), 32'h09);
    @(negedge clk);
    checkOutput("t1DonePulse", 32'(bus0.done), 32'd0);
    checkOutput("t1CsIdle", {30'd0, bus0.CS, bus0.busy}, 32'd2);
    checkOutput("t1CsLow", 32'(csLow0 - bCs), 32'd36);
    checkOutput("t1Rises", 32'(riseCount0 - bRise), 32'd8);
    checkOutput("t1Dones", 32'(doneCount0 - bDone), 32'd1);
`ifdef SPI_MASTER_MSB_FIRST_EN
    checkOutput("t1MosiSeq", 32'(mosiSeq0), 32'hCA);
`else
    checkOutput("t1MosiSeq", 32'(mosiSeq0), 32'h53);
`endif
    repeat (5) @(negedge clk);
    checkOutput("t1RxHeld", 32'(bus0.masterDataReceived), 32'h09);

    // Start while busy is ignored
    slaveData = 8'hC3;
    bRise = riseCount0; bCs = csLow0; bDone = doneCount0;
    applyStimulus(8'h5C);
    repeat (9) @(negedge clk);
    applyStimulus(8'hFF);
    waitDone0(100);
    checkOutput("t2Rx", 32'(bus0.masterDataReceived), 32'hC3);
    repeat (40) @(negedge clk);
    checkOutput("t2Dones", 32'(doneCount0 - bDone), 32'd1);
    checkOutput("t2CsLow", 32'(csLow0 - bCs), 32'd36);
`ifdef SPI_MASTER_MSB_FIRST_EN
    checkOutput("t2MosiSeq", 32'(mosiSeq0), 32'h3A);
`else
    checkOutput("t2MosiSeq", 32'(mosiSeq0), 32'h5C);
`endif

    // Reset mid-frame, then a clean frame
    slaveData = 8'hFF;
    bRise = riseCount0;
    applyStimulus(8'h81);
    begin
      int n = 0;
      while ((riseCount0 - bRise) < 4 && n < 100) begin
        @(posedge clk);
        #1;
        n = n + 1;
      end
      if ((riseCount0 - bRise) < 4) checkOutput("t3RiseTimeout", 32'd0, 32'd1);
    end
    #1 reset = 1'b0;
    #1;
    checkOutput("t3SclkAsync", 32'(bus0.SCLK), 32'd0);
    checkOutput("t3CsAsync", 32'(bus0.CS), 32'd1);
    checkOutput("t3BusyAsync", 32'(bus0.busy), 32'd0);
    checkOutput("t3RxCleared", 32'(bus0.masterDataReceived), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    slaveData = 8'h69;
    bRise = riseCount0; bCs = csLow0;
    applyStimulus(8'h96);
    waitDone0(100);
    checkOutput("t3Rx", 32'(bus0.masterDataReceived), 32'h69);
    @(negedge clk);
    checkOutput("t3CsLow", 32'(csLow0 - bCs), 32'd36);
    checkOutput("t3Rises", 32'(riseCount0 - bRise), 32'd8);
`ifdef SPI_MASTER_MSB_FIRST_EN
    checkOutput("t3MosiSeq", 32'(mosiSeq0), 32'h69);
`else
    checkOutput("t3MosiSeq", 32'(mosiSeq0), 32'h96);
`endif

    // Back-to-back frames, CLK_DIV=1, loopback
    bus1.masterDataToSend = 8'hA5;
    bus1.start = 1'b1;
    begin
      int n = 0;
      int seen = 0;
      while (bus1.busy !== 1'b1 && n < 20) begin
        @(negedge clk);
        n = n + 1;
      end
      bus1.masterDataToSend = 8'h3C;
      n = 0;
      while (seen < 2 && n < 200) begin
        @(negedge clk);
        if (bus1.done === 1'b1) seen = seen + 1;
        n = n + 1;
      end
      bus1.start = 1'b0;
      if (seen < 2) checkOutput("t4DoneTimeout", 32'(seen), 32'd2);
    end
    repeat (30) @(negedge clk);
    checkOutput("t4Frames", 32'(nLow1), 32'd2);
    checkOutput("t4Dones", 32'(nDone1), 32'd2);
    checkOutput("t4CsLow0", 32'(lowLens1[0]), 32'd18);
    checkOutput("t4CsLow1", 32'(lowLens1[1]), 32'd18);
    checkOutput("t4Gap", 32'(gap1), 32'd2);
    checkOutput("t4Rx0", 32'(rxLog1[0]), 32'hA5);
    checkOutput("t4Rx1", 32'(rxLog1[1]), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: observed running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master (initiator) driving the existing SPI slave over SCLK/CS/MOSI/MISO.
- Mode 0: SCLK idles low, both ends sample on SCLK rising edge and shift on SCLK falling edge. Bit order is LSB-first by default.
- Converts a parallel start/done handshake from the local controller into one full-duplex DATA_WIDTH-bit frame.
- SCLK is generated internally by dividing the system clock.

Parameters:
- DATA_WIDTH, 8, bits per frame.
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- masterDataToSend  input  DATA_WIDTH  frame to transmit; latched on accepted start.
- masterDataReceived  output  DATA_WIDTH  last complete frame received from MISO.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at end of frame.
- SCLK  output  1  serial clock to slave.
- CS  output  1  active-low chip select.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - SCLK=0, CS=1, MOSI=0, busy=0, done=0, masterDataReceived=0.
  - State returns to IDLE and all counters clear.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - On start=1, latch masterDataToSend into txShift.
  - Drive CS=0, busy=1, and MOSI = bit 0 at the same edge.
  - Go to SETUP.
- SETUP:
  - Wait CLK_DIV cycles with SCLK=0, then go to SHIFT.
- SHIFT:
  - Toggle SCLK every CLK_DIV cycles, producing DATA_WIDTH rising and DATA_WIDTH falling edges.
  - At the clk edge that drives SCLK 0->1: shift MISO into rxShift at the position of the current bit index (LSB-first).
  - At the clk edge that drives SCLK 1->0: advance the bit index and drive MOSI with the next txShift bit.
  - After the last falling edge, MOSI holds its value and the state goes to HOLD.
- HOLD:
  - Wait CLK_DIV cycles with SCLK=0.
  - Then drive CS=1, busy=0, done=1 for one cycle, and masterDataReceived=rxShift, all at the same edge.
  - Return to IDLE.
- Frame timing:
  - CS is low for exactly (2*DATA_WIDTH+2)*CLK_DIV clk cycles (36 at defaults).
  - done rises in the same cycle that CS returns high.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle as done is also ignored. The next frame needs start in IDLE, which gives at least one idle cycle with CS=1 between frames.
- masterDataToSend may change after acceptance with no effect on the frame in progress.
- masterDataReceived changes only at done; it holds its value across IDLE periods.
- CLK_DIV=1: SCLK is clk/2. All rules above still hold.
- Bit index counter width is clog2(DATA_WIDTH)+1; divide counter width is clog2(CLK_DIV)+1. Both wrap to 0 on state exit.

Optional Feature:
- Macro: SPI_MASTER_MSB_FIRST_EN.
- Defined: bit order is MSB-first.
  - MOSI starts with bit DATA_WIDTH-1.
  - rxShift shifts left, so the first sampled MISO bit ends in bit DATA_WIDTH-1.
  - The slave must be configured to match.
- Undefined: LSB-first exactly as in Behaviour.
- Frame timing and handshake are identical in both builds.

Test Plan:
- Basic frame at defaults:
  - Stimulus: reset low, then high; masterDataToSend=8'b01010011, start pulsed; slave model returns 8'b00001001 LSB-first.
  - Response: MOSI bits on successive SCLK rises are 1,1,0,0,1,0,1,0; masterDataReceived=8'h09 at done; CS low for 36 clk cycles; exactly 8 SCLK rising edges.
- Start while busy:
  - Stimulus: pulse start again 10 cycles into a frame with masterDataToSend=8'hFF.
  - Response: no effect; the frame completes with its original data; exactly one done pulse.
- Reset mid-frame:
  - Stimulus: assert reset after the 4th SCLK rise.
  - Response: SCLK=0, CS=1, busy=0 immediately, without waiting for a clk edge; masterDataReceived=0; a new start after release runs a clean full frame.
- Back-to-back frames with CLK_DIV=1:
  - Stimulus: frames 8'hA5 then 8'h3C; start held high continuously.
  - Response: each frame has CS low for 18 cycles; CS is high for at least 1 cycle between frames; two done pulses; received data matches the loopback (MISO tied to MOSI): 8'hA5 then 8'h3C.
- SPI_MASTER_MSB_FIRST_EN defined:
  - Stimulus: masterDataToSend=8'b01010011 with MISO tied to MOSI.
  - Response: MOSI order is 0,1,0,1,0,0,1,1; masterDataReceived=8'h53.
